// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared types and helpers for the FIFO read-side streamer.
//   occ_e     - two-entry buffer occupancy (EMPTY / ONE / FULL)
//   cnt_width - width of a counter that must hold 0..n-1 (at least 1 bit)
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_pkt_beat_cnt.sv
// pkt_beat_cnt: packet beat counter, 0..PKT_LEN-1, wrapping after the last beat.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - synchronous active-low reset (count -> 0)
//   inc     - a beat was accepted this cycle
//   at_last - current count is the final beat of the packet
module pkt_beat_cnt
  import fifo_stream_pkg::*;
#(
  parameter int PKT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic at_last
);

  localparam int CW = cnt_width(PKT_LEN);
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // PKT_LEN=1 gives LAST=0 with a count that never moves, so every beat is last.
  assign at_last = (cnt_q == LAST);

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a show-ahead FIFO into a valid/ready stream through a
// two-entry buffer (head + skid), so the pop request never depends on m_ready.
// Optional packet framing (m_last) is built when FIFO_RD_STREAM_LAST_EN is defined;
// otherwise m_last is tied low.
// Ports:
//   rd_clk, rd_rst_n      - clock; synchronous active-low reset
//   fifo_empty            - upstream FIFO empty flag
//   fifo_rd_data          - upstream head word (valid while fifo_empty=0)
//   fifo_rd_en            - pop request to upstream FIFO
//   m_valid/m_ready       - output handshake
//   m_data, m_last        - output payload, final beat of packet
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  if (PKT_LEN < 1 || PKT_LEN > 256) begin : g_bad_pkt_len
    $error("fifo_rd_stream: PKT_LEN must be in 1..256");
  end

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  push, pull;

  // Pop whenever there is room; the skid entry absorbs the word popped in the
  // cycle the consumer stalls, which keeps m_ready out of this path.
  assign fifo_rd_en = ~fifo_empty & (occ_q != FULL) & rd_rst_n;
  assign push       = fifo_rd_en;
  assign pull       = m_valid & m_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    unique case (occ_q)
      EMPTY: begin
        if (push) begin
          occ_d  = ONE;
          head_d = fifo_rd_data;
        end
      end
      ONE: begin
        if (push && pull) begin
          head_d = fifo_rd_data;
        end else if (push) begin
          occ_d  = FULL;
          skid_d = fifo_rd_data;
        end else if (pull) begin
          occ_d  = EMPTY;
        end
      end
      FULL: begin
        // push cannot occur here: fifo_rd_en is masked while FULL
        if (pull) begin
          occ_d  = ONE;
          head_d = skid_q;
        end
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign m_valid = (occ_q != EMPTY);
  assign m_data  = head_q;

`ifdef FIFO_RD_STREAM_LAST_EN
  logic at_last;

  pkt_beat_cnt #(
    .PKT_LEN (PKT_LEN)
  ) u_beat_cnt (
    .clk     (rd_clk),
    .rst_n   (rd_rst_n),
    .inc     (pull),
    .at_last (at_last)
  );

  assign m_last = m_valid & at_last;
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed-vector and scoreboard bench for fifo_rd_stream (DATA_WIDTH=8, PKT_LEN=4).
module tb_fifo_rd_stream;
  import fifo_stream_pkg::*;

  localparam int PKT = 4;
`ifdef FIFO_RD_STREAM_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic       rd_clk, rd_rst_n;
  logic       fifo_empty, fifo_rd_en;
  logic [7:0] fifo_rd_data, m_data;
  logic       m_valid, m_ready, m_last;

  // Source: either driven directly by vectors, or a show-ahead FIFO model.
  logic       use_mdl, gate_empty, drv_empty;
  logic [7:0] drv_data;
  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign fifo_empty   = use_mdl ? (gate_empty | (rd_ptr == wr_ptr)) : drv_empty;
  assign fifo_rd_data = use_mdl ? mem[rd_ptr[11:0]] : drv_data;

  always @(posedge rd_clk)
    if (use_mdl && fifo_rd_en) rd_ptr <= rd_ptr + 1;

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(PKT)) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_chk = 0, n_pass = 0;
  int exp_ptr = 0, beat_idx = 0, beats = 0, lasts = 0;
  bit mon_en = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // One clock: scoreboard the beat accepted at the coming edge, then step past it.
  task automatic cyc();
    @(negedge rd_clk);
    if (mon_en && m_valid && m_ready) begin
      check("beat_data", m_data, mem[exp_ptr[11:0]]);
      check("beat_last", m_last, LAST_EN && (beat_idx % PKT == PKT - 1));
      if (m_last) lasts++;
      exp_ptr++; beat_idx++; beats++;
    end
    @(posedge rd_clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[11:0]] = d;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0; m_ready = 1'b0;
    cyc();
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    cyc();
    rd_rst_n = 1'b1;
    exp_ptr = rd_ptr; beat_idx = 0; beats = 0; lasts = 0;
  endtask

  task automatic run_beats(input int n, input int bound);
    int c;
    c = 0;
    while (beats < n && c < bound) begin cyc(); c++; end
    check("beat_timeout", beats >= n, 1);
  endtask

  typedef struct {
    logic       empty;
    logic [7:0] din;
    logic       rdy;
    logic       e_rd_en;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
  } vec_t;

  vec_t vec [18];

  initial begin
    // streaming 0x11..0x44
    vec[0]  = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vec[1]  = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    vec[2]  = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vec[3]  = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0};
    vec[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, LAST_EN};
    vec[5]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    // backpressure: 5 stalled cycles, exactly 2 pops, head holds 0x11
    vec[6]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vec[7]  = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    vec[8]  = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vec[9]  = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vec[10] = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vec[11] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    vec[12] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vec[13] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
    // m_ready while idle must not advance the beat count
    vec[14] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[15] = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vec[16] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, LAST_EN};
    vec[17] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    use_mdl = 1'b0; gate_empty = 1'b0; drv_empty = 1'b0; drv_data = 8'h99;
    rd_rst_n = 1'b0; m_ready = 1'b0;
    @(posedge rd_clk); #1;
    do_reset();  // fifo_empty=0 here, so rd_en=0 is down to reset alone

    for (int i = 0; i < 18; i++) begin
      drv_empty = vec[i].empty; drv_data = vec[i].din; m_ready = vec[i].rdy;
      @(negedge rd_clk);
      check($sformatf("v%0d_rd_en", i), fifo_rd_en, vec[i].e_rd_en);
      check($sformatf("v%0d_valid", i), m_valid, vec[i].e_valid);
      if (vec[i].e_valid) check($sformatf("v%0d_data", i), m_data, vec[i].e_data);
      check($sformatf("v%0d_last", i), m_last, vec[i].e_last);
      @(posedge rd_clk); #1;
    end

    // packet wrap over 10 beats
    use_mdl = 1'b1; gate_empty = 1'b0; mon_en = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) push(8'h60 + 8'(i));
    m_ready = 1'b1;
    run_beats(10, 50);
    check("wrap_lasts", lasts, LAST_EN ? 2 : 0);

    // bubbles: empty toggles every cycle
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    m_ready = 1'b1;
    begin
      bit saw_drop;
      int c;
      saw_drop = 0; c = 0;
      while (beats < 8 && c < 100) begin
        gate_empty = ~gate_empty;
        cyc(); c++;
        if (beats > 0 && beats < 8 && !m_valid) saw_drop = 1;
      end
      check("bub_beats", beats, 8);
      check("bub_valid_drop", saw_drop, 1);
      gate_empty = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      check("bub_no_dup", beats, 8);
      check("bub_idle_valid", m_valid, 0);
    end

    // reset mid-packet with the buffer FULL
    do_reset();
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    m_ready = 1'b1;
    cyc(); cyc(); cyc();
    m_ready = 1'b0;
    cyc();
    check("mid_beats", beats, 2);
    check("mid_full_rd_en", fifo_rd_en, 0);
    check("mid_full_valid", m_valid, 1);
    rd_rst_n = 1'b0;
    cyc();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    cyc();
    check("mid_rst_rd_en2", fifo_rd_en, 0);
    rd_rst_n = 1'b1;
    exp_ptr = rd_ptr; beat_idx = 0; beats = 0; lasts = 0;
    check("mid_resume_ptr", exp_ptr, wr_ptr - 4);
    m_ready = 1'b1;
    run_beats(4, 50);
    check("mid_lasts", lasts, LAST_EN ? 1 : 0);

    // random m_ready and source gaps over 1000 beats
    do_reset();
    for (int i = 0; i < 1000; i++) push(8'($urandom));
    begin
      int c;
      c = 0;
      while (beats < 1000 && c < 20000) begin
        m_ready    = 1'($urandom_range(0, 1));
        gate_empty = ($urandom_range(0, 3) == 0);
        cyc(); c++;
      end
      check("rand_beats", beats, 1000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter PKT_LEN, default 4, beats per packet; legal range 1..256.
REQ-003 SHALL have port rd_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rd_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fifo_empty  input  1  empty flag from the upstream FIFO read port.
REQ-006 SHALL have port fifo_rd_data  input  DATA_WIDTH  show-ahead head word; valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_rd_en  output  1  pop request to the upstream FIFO.
REQ-008 SHALL have port m_valid  output  1  output beat valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts the beat.
REQ-010 SHALL have port m_data  output  DATA_WIDTH  output beat payload.
REQ-011 SHALL have port m_last  output  1  final beat of a packet.

Function
REQ-012 SHALL hold a 2-entry buffer (head register, skid register) with occupancy state EMPTY, ONE or FULL.
REQ-013 SHALL drive fifo_rd_en = ~fifo_empty & (occ != FULL) & rd_rst_n, with no combinational path from m_ready.
REQ-014 SHALL define push = fifo_rd_en and pull = m_valid & m_ready; occupancy next = occ + push - pull.
REQ-015 SHALL implement these transitions: EMPTY+push -> ONE (fifo_rd_data to head); ONE+push+pull -> ONE (fifo_rd_data to head); ONE+push only -> FULL (fifo_rd_data to skid); ONE+pull only -> EMPTY; FULL+pull -> ONE (skid to head); otherwise hold.
REQ-016 SHALL drive m_valid = (occ != EMPTY) and m_data = head register, both directly from registers.
REQ-017 SHALL give one-cycle latency: a word that pops at edge t is on m_data with m_valid=1 after edge t.
REQ-018 SHALL sustain one beat per cycle while fifo_empty=0 and m_ready=1.
REQ-019 SHALL keep m_data and m_last stable while m_valid=1 and m_ready=0, and SHALL never drop or duplicate a word.
REQ-020 SHALL preserve FIFO order across head/skid handoff.
REQ-021 SHALL ignore m_ready while m_valid=0.

Reset
REQ-022 SHALL, while rd_rst_n=0 at a rising edge, set occ=EMPTY, head=0, skid=0 and beat counter=0.
REQ-023 SHALL hold fifo_rd_en=0 combinationally while rd_rst_n=0, so that no pop occurs during reset.
REQ-024 SHALL, on reset mid-packet, discard buffered words and restart the beat count at 0; m_valid=0 and m_last=0 in the first cycle after reset.

Configuration
REQ-025 SHALL honour macro FIFO_RD_STREAM_LAST_EN.
REQ-026 SHALL, with the macro defined, keep a beat counter 0..PKT_LEN-1 that increments on pull, wraps to 0 after PKT_LEN-1, and drive m_last = m_valid & (count == PKT_LEN-1); with PKT_LEN=1, m_last = m_valid.
REQ-027 SHALL, with the macro undefined, omit the counter and tie m_last to 0; all other behaviour SHALL be unchanged.

Structure
REQ-028 SHALL take the occupancy enum type (EMPTY/ONE/FULL) and the beat-counter width function from shared package fifo_stream_pkg.
REQ-029 SHALL put the packet beat counter in sub-module pkt_beat_cnt, instantiated only under FIFO_RD_STREAM_LAST_EN.

Verification
REQ-030 Bench SHALL cover streaming: FIFO holds 0x11,0x22,0x33,0x44 and m_ready=1 -> m_data 0x11..0x44 on 4 consecutive cycles starting one cycle after the first pop; m_last=1 only on 0x44.
REQ-031 Bench SHALL cover backpressure: m_ready=0 for 5 cycles with the FIFO non-empty -> exactly 2 pops, then fifo_rd_en=0; m_data holds 0x11; after release, order is 0x11,0x22,0x33.
REQ-032 Bench SHALL cover bubbles: fifo_empty toggles each cycle and m_ready=1 -> no duplicate beats, and m_valid drops when the buffer drains.
REQ-033 Bench SHALL cover packet wrap: 10 beats with PKT_LEN=4 -> m_last asserted on beats 4 and 8 only; with the macro undefined, m_last=0 throughout.
REQ-034 Bench SHALL cover reset mid-packet: rd_rst_n=0 after 2 accepted beats with occ=FULL -> next cycle m_valid=0 and fifo_rd_en=0 during reset; after release, the first 4 beats end with m_last on the 4th.
REQ-035 Bench SHALL cover random m_ready over 1000 beats -> output sequence equals input sequence, checked by a scoreboard.
